// File: rtl/cache_lines.sv
// Multi-line read cache between the bus front end and the SDRAM controller.
// Lines fill sequentially from an SDRAM burst. Two write-snoop ports keep cached
// words coherent with bus writes, and invalidate drops one line or every line.
module cache_lines #(
  parameter int unsigned AW      = 26,
  parameter int unsigned LW_LOG2 = 2,
  parameter int unsigned NL_LOG2 = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_req,
  input  logic [AW-1:0]      rd_addr,
  output logic               rd_hit,
  output logic [15:0]        rd_data,
  input  logic               fill_start,
  input  logic [AW-1:0]      fill_addr,
  input  logic               fill_valid,
  input  logic [15:0]        fill_data,
  output logic               fill_busy,
  output logic [NL_LOG2-1:0] fill_line,
  input  logic               upd_a,
  input  logic [1:0]         umask_a,
  input  logic [AW-1:0]      uaddr_a,
  input  logic [15:0]        udata_a,
  input  logic               upd_b,
  input  logic [1:0]         umask_b,
  input  logic [AW-1:0]      uaddr_b,
  input  logic [15:0]        udata_b,
  input  logic               inv_one,
  input  logic               inv_all,
  input  logic [AW-1:0]      iaddr
);

  localparam int unsigned NL = 1 << NL_LOG2;
  localparam int unsigned LW = 1 << LW_LOG2;
  localparam int unsigned TW = AW - LW_LOG2 - 1;
  localparam int unsigned IW = NL_LOG2 + LW_LOG2;

  // Returns {hit, line}; the lowest matching valid line wins.
  function automatic logic [NL_LOG2:0] find_line(input logic [NL-1:0][TW-1:0] tags,
                                                 input logic [NL-1:0]         vld,
                                                 input logic [TW-1:0]         t);
    logic [NL_LOG2:0] r;
    r = '0;
    for (int i = NL - 1; i >= 0; i--) begin
      if (vld[i] && tags[i] == t) r = {1'b1, NL_LOG2'(i)};
    end
    return r;
  endfunction

  // State
  logic [NL-1:0][TW-1:0] tag_q, tag_d;
  logic [NL-1:0]         tag_valid_q, tag_valid_d;
  logic [NL*LW-1:0]      word_valid_q, word_valid_d;
  logic [15:0]           data_q [NL*LW];
  logic                  rd_hit_q, rd_hit_d;
  logic [15:0]           rd_data_q, rd_data_d;
  logic                  fill_busy_q, fill_busy_d;
  logic [NL_LOG2-1:0]    fill_line_q, fill_line_d;
  logic [LW_LOG2-1:0]    fill_cnt_q, fill_cnt_d;
  logic [NL_LOG2-1:0]    rr_q, rr_d;
  // Set when the current fill allocated a fresh line, so completion advances rr.
  logic                  fill_new_q, fill_new_d;

  // Decode
  logic [NL_LOG2:0]   rd_m, inv_m, fl_m, a_m, b_m;
  logic [IW-1:0]      rd_idx, idx_a, idx_b, fill_idx;
  logic               rd_hit_w;
  logic [NL-1:0]      inv_line;
  logic [1:0]         be_a, be_b;
  logic               same_word;
  logic               fill_step, fill_abort, fill_wr, start;
  logic [NL_LOG2-1:0] start_line;

  // Tag lookups for every port and the per-cycle write enables derived from them.
  always_comb begin
    rd_m  = find_line(tag_q, tag_valid_q, rd_addr[AW-1:LW_LOG2+1]);
    inv_m = find_line(tag_q, tag_valid_q, iaddr[AW-1:LW_LOG2+1]);
    fl_m  = find_line(tag_q, tag_valid_q, fill_addr[AW-1:LW_LOG2+1]);
    a_m   = find_line(tag_q, tag_valid_q, uaddr_a[AW-1:LW_LOG2+1]);
    b_m   = find_line(tag_q, tag_valid_q, uaddr_b[AW-1:LW_LOG2+1]);

    rd_idx   = {rd_m[NL_LOG2-1:0], rd_addr[LW_LOG2:1]};
    idx_a    = {a_m[NL_LOG2-1:0], uaddr_a[LW_LOG2:1]};
    idx_b    = {b_m[NL_LOG2-1:0], uaddr_b[LW_LOG2:1]};
    fill_idx = {fill_line_q, fill_cnt_q};
    rd_hit_w = rd_m[NL_LOG2] && word_valid_q[rd_idx];

    inv_line = {NL{inv_all}};
    if (inv_one && inv_m[NL_LOG2]) inv_line[inv_m[NL_LOG2-1:0]] = 1'b1;

    // Snoops into a line being invalidated on this edge are dropped.
    be_a = (upd_a && a_m[NL_LOG2] && !inv_line[a_m[NL_LOG2-1:0]]) ? ~umask_a : 2'b00;
    be_b = (upd_b && b_m[NL_LOG2] && !inv_line[b_m[NL_LOG2-1:0]]) ? ~umask_b : 2'b00;
    same_word = (idx_a == idx_b);

    fill_abort = fill_busy_q && inv_line[fill_line_q];
    fill_step  = fill_busy_q && fill_valid && !inv_line[fill_line_q];
    // Snoop data always beats the SDRAM word, as does an already-valid word.
    fill_wr    = fill_step && !word_valid_q[fill_idx]
                 && !((be_a != 2'b00) && (idx_a == fill_idx))
                 && !((be_b != 2'b00) && (idx_b == fill_idx));
    start      = fill_start && !fill_busy_q && !inv_all && !inv_one;
    start_line = fl_m[NL_LOG2] ? fl_m[NL_LOG2-1:0] : rr_q;
  end

  // Next-state for lookup, fill sequencing, snoop validity and invalidation.
  always_comb begin
    tag_d        = tag_q;
    tag_valid_d  = tag_valid_q & ~inv_line;
    word_valid_d = word_valid_q;
    rd_hit_d     = rd_req && rd_hit_w;
    rd_data_d    = (rd_req && rd_hit_w) ? data_q[rd_idx] : rd_data_q;
    fill_busy_d  = fill_busy_q;
    fill_line_d  = fill_line_q;
    fill_cnt_d   = fill_cnt_q;
    rr_d         = rr_q;
    fill_new_d   = fill_new_q;

    if (start) begin
      tag_d[start_line]       = fill_addr[AW-1:LW_LOG2+1];
      tag_valid_d[start_line] = 1'b1;
      word_valid_d[{start_line, {LW_LOG2{1'b0}}} +: LW] = '0;
      fill_line_d = start_line;
      fill_cnt_d  = '0;
      fill_busy_d = 1'b1;
      fill_new_d  = !fl_m[NL_LOG2];
    end

    // A word becomes valid only once both of its bytes are known.
    if ((be_a | (same_word ? be_b : 2'b00)) == 2'b11) word_valid_d[idx_a] = 1'b1;
    if ((be_b | (same_word ? be_a : 2'b00)) == 2'b11) word_valid_d[idx_b] = 1'b1;

    if (fill_abort) begin
      fill_busy_d = 1'b0;
      fill_cnt_d  = '0;
    end else if (fill_step) begin
      word_valid_d[fill_idx] = 1'b1;
      fill_cnt_d = fill_cnt_q + 1'b1;
      if (fill_cnt_q == LW_LOG2'(LW - 1)) begin
        fill_busy_d = 1'b0;
        if (fill_new_q) rr_d = rr_q + 1'b1;
      end
    end
  end

  // Control and tag state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_q        <= '0;
      tag_valid_q  <= '0;
      word_valid_q <= '0;
      rd_hit_q     <= 1'b0;
      rd_data_q    <= '0;
      fill_busy_q  <= 1'b0;
      fill_line_q  <= '0;
      fill_cnt_q   <= '0;
      rr_q         <= '0;
      fill_new_q   <= 1'b0;
    end else begin
      tag_q        <= tag_d;
      tag_valid_q  <= tag_valid_d;
      word_valid_q <= word_valid_d;
      rd_hit_q     <= rd_hit_d;
      rd_data_q    <= rd_data_d;
      fill_busy_q  <= fill_busy_d;
      fill_line_q  <= fill_line_d;
      fill_cnt_q   <= fill_cnt_d;
      rr_q         <= rr_d;
      fill_new_q   <= fill_new_d;
    end
  end

  // Data RAM byte writes; port a is applied last so it wins shared bytes.
  always_ff @(posedge clk) begin
    if (be_b[0]) data_q[idx_b][7:0]  <= udata_b[7:0];
    if (be_b[1]) data_q[idx_b][15:8] <= udata_b[15:8];
    if (be_a[0]) data_q[idx_a][7:0]  <= udata_a[7:0];
    if (be_a[1]) data_q[idx_a][15:8] <= udata_a[15:8];
    if (fill_wr) data_q[fill_idx]    <= fill_data;
  end

  assign rd_hit    = rd_hit_q;
  assign rd_data   = rd_data_q;
  assign fill_busy = fill_busy_q;
  assign fill_line = fill_line_q;

  // Byte-offset bits are don't-care for every address port.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr[0], fill_addr[LW_LOG2:0], uaddr_a[0], uaddr_b[0],
                              iaddr[LW_LOG2:0]};

endmodule

// File: tb/tb_cache_lines.sv
// Bench for cache_lines: directed scenarios followed by random traffic, all
// checked against a line/word array model of the cache rules.
module tb_cache_lines;
  localparam int AW = 26, LW_LOG2 = 2, NL_LOG2 = 2;
  localparam int NL = 1 << NL_LOG2, LW = 1 << LW_LOG2, TW = AW - LW_LOG2 - 1;

  logic clk = 1'b0, reset;
  logic rd_req, fill_start, fill_valid, upd_a, upd_b, inv_one, inv_all, fill_busy, rd_hit;
  logic [AW-1:0] rd_addr, fill_addr, uaddr_a, uaddr_b, iaddr;
  logic [15:0] fill_data, udata_a, udata_b, rd_data;
  logic [1:0] umask_a, umask_b;
  logic [NL_LOG2-1:0] fill_line;

  cache_lines #(.AW(AW), .LW_LOG2(LW_LOG2), .NL_LOG2(NL_LOG2)) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_addr(rd_addr), .rd_hit(rd_hit),
    .rd_data(rd_data), .fill_start(fill_start), .fill_addr(fill_addr),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_busy(fill_busy),
    .fill_line(fill_line), .upd_a(upd_a), .umask_a(umask_a), .uaddr_a(uaddr_a),
    .udata_a(udata_a), .upd_b(upd_b), .umask_b(umask_b), .uaddr_b(uaddr_b),
    .udata_b(udata_b), .inv_one(inv_one), .inv_all(inv_all), .iaddr(iaddr)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Model state
  logic [TW-1:0] m_tag [NL];
  bit            m_tv [NL];
  bit            m_wv [NL][LW];
  logic [15:0]   m_data [NL][LW];
  bit            m_busy, m_new;
  int            m_line, m_cnt, m_rr;
  bit            exp_hit;
  logic [15:0]   exp_data;

  function automatic logic [TW-1:0] tg(input logic [AW-1:0] a);
    return a[AW-1:LW_LOG2+1];
  endfunction

  function automatic int wrd(input logic [AW-1:0] a);
    return int'(a[LW_LOG2:1]);
  endfunction

  function automatic int mfind(input logic [AW-1:0] a);
    for (int i = 0; i < NL; i++) if (m_tv[i] && m_tag[i] == tg(a)) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_tv[i] = 0;
      for (int w = 0; w < LW; w++) m_wv[i][w] = 0;
    end
    m_busy = 0; m_new = 0; m_line = 0; m_cnt = 0; m_rr = 0;
  endtask

  // Applies one clock edge of cache rules to the model, from the current inputs.
  task automatic model_step();
    int l, la, lb, wa, wb;
    bit [1:0] ba, bb;
    bit same;
    exp_hit = 0;
    if (!reset) begin
      model_reset();
      exp_data = 16'h0;
      return;
    end
    if (rd_req) begin
      l = mfind(rd_addr);
      if (l >= 0 && m_wv[l][wrd(rd_addr)]) begin
        exp_hit = 1;
        exp_data = m_data[l][wrd(rd_addr)];
      end
    end
    if (inv_all || inv_one) begin
      for (int i = 0; i < NL; i++) begin
        if (inv_all || (m_tv[i] && m_tag[i] == tg(iaddr))) begin
          if (m_busy && m_line == i) begin m_busy = 0; m_cnt = 0; end
          m_tv[i] = 0;
        end
      end
      return;
    end
    if (m_busy && fill_valid) begin
      if (!m_wv[m_line][m_cnt]) m_data[m_line][m_cnt] = fill_data;
      m_wv[m_line][m_cnt] = 1;
      m_cnt++;
      if (m_cnt == LW) begin
        m_cnt = 0; m_busy = 0;
        if (m_new) m_rr = (m_rr + 1) % NL;
      end
    end else if (fill_start && !m_busy) begin
      l = mfind(fill_addr);
      m_new = (l < 0);
      if (l < 0) l = m_rr;
      m_tag[l] = tg(fill_addr); m_tv[l] = 1;
      for (int w = 0; w < LW; w++) m_wv[l][w] = 0;
      m_line = l; m_cnt = 0; m_busy = 1;
    end
    la = upd_a ? mfind(uaddr_a) : -1;
    lb = upd_b ? mfind(uaddr_b) : -1;
    wa = wrd(uaddr_a); wb = wrd(uaddr_b);
    ba = (la >= 0) ? ~umask_a : 2'b00;
    bb = (lb >= 0) ? ~umask_b : 2'b00;
    if (bb[0]) m_data[lb][wb][7:0]  = udata_b[7:0];
    if (bb[1]) m_data[lb][wb][15:8] = udata_b[15:8];
    if (ba[0]) m_data[la][wa][7:0]  = udata_a[7:0];
    if (ba[1]) m_data[la][wa][15:8] = udata_a[15:8];
    same = (la >= 0) && (la == lb) && (wa == wb);
    if (la >= 0 && ((ba | (same ? bb : 2'b00)) == 2'b11)) m_wv[la][wa] = 1;
    if (lb >= 0 && ((bb | (same ? ba : 2'b00)) == 2'b11)) m_wv[lb][wb] = 1;
  endtask

  task automatic idle();
    reset = 1; rd_req = 0; rd_addr = '0; fill_start = 0; fill_addr = '0;
    fill_valid = 0; fill_data = '0; upd_a = 0; upd_b = 0; umask_a = 2'b11;
    umask_b = 2'b11; uaddr_a = '0; uaddr_b = '0; udata_a = '0; udata_b = '0;
    inv_one = 0; inv_all = 0; iaddr = '0;
  endtask

  // One clock with the current inputs, then compare against the model.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("rd_hit", rd_hit, exp_hit);
    if (exp_hit) chk("rd_data", rd_data, exp_data);
    chk("fill_busy", fill_busy, m_busy);
    chk("fill_line", fill_line, m_line[NL_LOG2-1:0]);
    idle();
  endtask

  task automatic rd(input logic [AW-1:0] a);
    rd_req = 1; rd_addr = a; step();
  endtask

  task automatic do_fill(input logic [AW-1:0] a, input logic [15:0] base);
    fill_start = 1; fill_addr = a; step();
    for (int k = 0; k < LW; k++) begin
      fill_valid = 1; fill_data = base + 16'(k); step();
    end
  endtask

  initial begin
    idle();
    reset = 0;
    step();
    chk("reset_rd_data", rd_data, 16'h0);
    chk("reset_rd_hit", rd_hit, 1'b0);
    chk("reset_busy", fill_busy, 1'b0);

    // T1: sequential fill, then a lookup of word 2
    fill_start = 1; fill_addr = 26'h001000; step();
    chk("t1_busy_start", fill_busy, 1'b1);
    for (int k = 0; k < 4; k++) begin
      fill_valid = 1; fill_data = 16'h1111 * 16'(k + 1); step();
      chk("t1_busy_word", fill_busy, (k < 3) ? 1'b1 : 1'b0);
    end
    rd(26'h001004);
    chk("t1_hit", rd_hit, 1'b1);
    chk("t1_data", rd_data, 16'h3333);
    rd(26'h001008);
    chk("t1_other_line_miss", rd_hit, 1'b0);

    // T2: snoop lands before its fill word, fill word is discarded
    fill_start = 1; fill_addr = 26'h2000; step();
    fill_valid = 1; fill_data = 16'hAAAA; step();
    upd_a = 1; uaddr_a = 26'h2002; umask_a = 2'b00; udata_a = 16'hABCD; step();
    for (int k = 1; k < 4; k++) begin
      fill_valid = 1; fill_data = 16'h5555; step();
    end
    rd(26'h2002);
    chk("t2_hit", rd_hit, 1'b1);
    chk("t2_data", rd_data, 16'hABCD);

    // T3: five fills into four lines evict line 0
    idle(); reset = 0; step();
    for (int k = 0; k < 5; k++) do_fill(26'(k * 8), 16'(16'h0100 * (k + 1)));
    rd(26'h0);
    chk("t3_evicted_miss", rd_hit, 1'b0);
    rd(26'h20);
    chk("t3_new_hit", rd_hit, 1'b1);
    chk("t3_new_data", rd_data, 16'h0500);

    // T4: both snoop ports merge into one word
    upd_a = 1; uaddr_a = 26'h8; umask_a = 2'b10; udata_a = 16'h0011;
    upd_b = 1; uaddr_b = 26'h8; umask_b = 2'b01; udata_b = 16'h2200;
    step();
    rd(26'h8);
    chk("t4_merge", rd_data, 16'h2211);

    // T5: invalidate a filling line, then everything
    fill_start = 1; fill_addr = 26'h40; step();
    for (int k = 0; k < 2; k++) begin
      fill_valid = 1; fill_data = 16'h7700 + 16'(k); step();
    end
    inv_one = 1; iaddr = 26'h40; step();
    chk("t5_abort", fill_busy, 1'b0);
    fill_valid = 1; fill_data = 16'h7777; step();
    chk("t5_ignored", fill_busy, 1'b0);
    rd(26'h40);
    chk("t5_miss", rd_hit, 1'b0);
    inv_all = 1; step();
    rd(26'h8);
    chk("t5_all_miss_8", rd_hit, 1'b0);
    rd(26'h20);
    chk("t5_all_miss_20", rd_hit, 1'b0);

    // T6: reset mid-fill
    do_fill(26'h100, 16'h0A00);
    fill_start = 1; fill_addr = 26'h108; step();
    fill_valid = 1; fill_data = 16'h1; step();
    reset = 0; rd_req = 1; rd_addr = 26'h100; step();
    chk("t6_busy", fill_busy, 1'b0);
    chk("t6_hit", rd_hit, 1'b0);
    rd(26'h100);
    chk("t6_miss", rd_hit, 1'b0);

    // Random traffic over a small address window to force reuse and conflicts
    for (int n = 0; n < 3000; n++) begin
      int r;
      idle();
      reset = ($urandom_range(0, 599) != 0);
      rd_req = 1'($urandom_range(0, 1));
      rd_addr = 26'($urandom_range(0, 63));
      r = $urandom_range(0, 63);
      if (r == 0) inv_all = 1;
      else if (r < 3) begin inv_one = 1; iaddr = 26'($urandom_range(0, 63)); end
      else begin
        fill_start = ($urandom_range(0, 7) == 0);
        fill_addr = 26'($urandom_range(0, 63));
        fill_valid = 1'($urandom_range(0, 1));
        fill_data = 16'($urandom);
        if (!fill_start) begin
          upd_a = ($urandom_range(0, 3) == 0);
          upd_b = ($urandom_range(0, 3) == 0);
          umask_a = 2'($urandom_range(0, 3));
          umask_b = 2'($urandom_range(0, 3));
          uaddr_a = 26'($urandom_range(0, 63));
          uaddr_b = 26'($urandom_range(0, 63));
          udata_a = 16'($urandom);
          udata_b = 16'($urandom);
          // A snoop racing the incoming fill word is kept full-width.
          if (m_busy && fill_valid && m_tv[m_line]) begin
            if (upd_a && tg(uaddr_a) == m_tag[m_line] && wrd(uaddr_a) == m_cnt) umask_a = 2'b00;
            if (upd_b && tg(uaddr_b) == m_tag[m_line] && wrd(uaddr_b) == m_cnt) umask_b = 2'b00;
          end
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
